hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the write side of the HI/LO register pair.
- Sits beside the EX-stage ALU. It accepts mult/div/madd/msub issues from EX and runs the operation over several cycles.
- Stalls the front pipeline (IF/DEC/EX) when a later instruction touches HI/LO or issues a new operation while it is busy.
- Arbitrates the HI/LO write port between its own result and WB-stage mthi/mtlo moves.

Parameters:
MUL_LATENCY, 4, cycles spent in MUL state (emulated pipelined multiplier); legal 1..15
DIV_CYCLES, 32, restoring-division iterations; fixed at 32 for 32-bit operands

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous, active-high reset
Start  in  1  EX-stage muldiv instruction valid
Op  in  3  operation code (package encoding)
OpA  in  32  rs operand / dividend
OpB  in  32  rt operand / divisor
HiLoRead  in  1  DEC-stage instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/madd/msub)
HiLoIn  in  64  current {HI,LO} register contents
MoveHiWe  in  1  WB mthi write request
MoveLoWe  in  1  WB mtlo write request
MoveData  in  32  WB move data
HiLoWe  out  2  {HI write, LO write} to HiLo registers
HiOut  out  32  HI write data
LoOut  out  32  LO write data
Busy  out  1  high in MUL, DIV, WRITE
Stall  out  1  freeze IF/DEC/EX registers this cycle
DivZero  out  1  one-cycle pulse in WRITE when divisor was zero

Behaviour:
- Clock and reset are decided: one clock (Clk); reset (Rst) is asynchronous and active-high.
- Reset: state IDLE, counter 0, operand/result registers 0. All outputs are 0 during and after reset. Reset mid-operation aborts it; no HI/LO write occurs.
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB. Codes 6/7 are ignored: not accepted, no stall.
- States: IDLE, MUL, DIV, WRITE.
- IDLE:
  - On Start with a legal Op, latch OpA, OpB and Op at edge E0.
  - MULT/MULTU/MADD/MSUB go to MUL with counter = MUL_LATENCY-1.
  - DIV/DIVU go to DIV with counter = DIV_CYCLES-1.
- MUL:
  - 64-bit product: signed for MULT/MADD/MSUB, unsigned for MULTU.
  - Decrement counter each cycle; go to WRITE when counter = 0.
  - MUL occupies exactly MUL_LATENCY cycles.
- DIV:
  - Signed ops divide magnitudes; one restoring step per cycle.
  - Go to WRITE after DIV_CYCLES cycles.
  - Sign fix-up is applied on entry to WRITE: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: LO = 0xFFFFFFFF, HI = dividend, DivZero = 1 in WRITE.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- WRITE:
  - HiLoWe = 2'b11; HI/LO take the result (HI = remainder for div).
  - MADD: {HI,LO} = HiLoIn + product. MSUB: HiLoIn - product. HiLoIn is sampled in this cycle, so older moves have already retired.
  - Next state IDLE.
- Latency: multiply writes in cycle MUL_LATENCY+1 after E0; divide writes in cycle DIV_CYCLES+1. Busy drops the following cycle.
- Port arbitration: if MoveHiWe or MoveLoWe is set during WRITE, the move wins. HiLoWe = {MoveHiWe, MoveLoWe}, data = MoveData, and the FSM stays in WRITE one more cycle. Outside WRITE, moves pass straight through to HiLoWe/HiOut/LoOut.
- Stall = Busy & (Start | HiLoRead); this is combinational. A stalled Start is re-presented by the pipeline and accepted in the first IDLE cycle.
- Start in IDLE with HiLoRead also high: accept, no stall.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: on DIV entry, if |OpB| > |OpA| or OpB = 0, DIV lasts one cycle. Result is quotient 0 / remainder OpA, or the div-by-zero values.
- Undefined: DIV always lasts DIV_CYCLES cycles; results are identical.

Decomposition:
- Shared package hilo_pkg: Op encoding constants, state encoding, the DIV_CYCLES constant, and the div-by-zero result constants.
- One sub-module, muldiv_div_step: a combinational restoring step taking {rem, quo, divisor} and returning the next {rem, quo}. It is instantiated once in the DIV path.

Test Plan:
- MULT OpA=0xFFFFFFFD, OpB=5, MUL_LATENCY=4 -> HiLoWe=11 in cycle 5, HI=0xFFFFFFFF, LO=0xFFFFFFF1; Busy low in cycle 6.
- DIVU 100/7 -> WRITE in cycle 33, LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 -> LO=0xFFFFFFFF, HI=5, DivZero pulse. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Second Start and HiLoRead each raised at cycle 2 of a MULT -> Stall=1 until IDLE; second op accepted the first IDLE cycle.
- MADD with HiLoIn=0x00000001_00000000, 2*3 -> HI=1, LO=6. MoveLoWe during WRITE -> LO=MoveData first, MADD result written next cycle.
- Rst pulse at DIV cycle 10 -> all outputs 0 immediately, no HiLoWe, Busy=0; new Start accepted after release.

Source files
------------

// File: rtl/hilo_pkg.sv
// ----------------------------------------------------------------------------
// hilo_pkg : op encoding, FSM states and constants for the HI/LO mul/div unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hilo_pkg;

    localparam int DIV_CYCLES = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    // Divide by zero: LO saturates, HI returns the dividend unchanged
    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DIV   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_MSUB);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op != OP_MULTU) && (op != OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_step.sv
// ----------------------------------------------------------------------------
// muldiv_div_step : one combinational restoring-division step on {rem, quo}
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] w_shift;
    logic        w_ge;

    assign w_shift = {rem_i, quo_i[31]};
    assign w_ge    = (w_shift >= {1'b0, div_i});
    // When w_ge holds the true difference is below the divisor, so 32 bits suffice
    assign rem_o   = w_ge ? (w_shift[31:0] - div_i) : w_shift[31:0];
    assign quo_o   = {quo_i[30:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl : multi-cycle mult/div/madd/msub sequencer owning the HI/LO
// write port. Optional macro MULDIV_EARLY_OUT_EN shortens trivial divides.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hilo_muldiv_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_CYCLES  = hilo_pkg::DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        HiLoRead,
    input  logic [63:0] HiLoIn,
    input  logic        MoveHiWe,
    input  logic        MoveLoWe,
    input  logic [31:0] MoveData,
    output logic [1:0]  HiLoWe,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Stall,
    output logic        DivZero
);

    import hilo_pkg::*;

    localparam int CNT_W = 5;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       dvs_q, dvs_d;
    logic [63:0]       res_q, res_d;
    logic              early_q, early_d;

    logic        w_accept;
    logic        w_move;
    logic        w_in_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_early;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_step_rem;
    logic [31:0] w_step_quo;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_div_res;
    logic [63:0] w_wr_data;

    assign w_accept    = (state_q == ST_IDLE) && Start && op_legal(Op);
    assign w_move      = ~Rst & (MoveHiWe | MoveLoWe);

    assign w_in_signed = op_is_signed(Op);
    assign w_abs_a     = (w_in_signed && OpA[31]) ? (32'd0 - OpA) : OpA;
    assign w_abs_b     = (w_in_signed && OpB[31]) ? (32'd0 - OpB) : OpB;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (w_abs_b > w_abs_a) || (OpB == 32'd0);
`else
    assign w_early = 1'b0;
`endif

    // Low 64 bits of the extended product are correct for both signednesses
    assign w_ext_a = op_is_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign w_ext_b = op_is_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign w_prod  = w_ext_a * w_ext_b;

    muldiv_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (w_step_rem),
        .quo_o (w_step_quo)
    );

    assign w_quo_fix = ((op_q == OP_DIV) && (a_q[31] ^ b_q[31])) ? (32'd0 - w_step_quo) : w_step_quo;
    assign w_rem_fix = ((op_q == OP_DIV) && a_q[31]) ? (32'd0 - w_step_rem) : w_step_rem;

    always_comb begin
        if (b_q == 32'd0) begin
            w_div_res = {a_q, DIVZ_LO};
        end else if (early_q) begin
            w_div_res = {a_q, 32'd0};
        end else begin
            w_div_res = {w_rem_fix, w_quo_fix};
        end
    end

    // HiLoIn is sampled in WRITE itself so any older move has already landed
    always_comb begin
        case (op_q)
            OP_MADD: w_wr_data = HiLoIn + res_q;
            OP_MSUB: w_wr_data = HiLoIn - res_q;
            default: w_wr_data = res_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        early_d = early_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d    = Op;
                    a_d     = OpA;
                    b_d     = OpB;
                    early_d = 1'b0;
                    if (op_is_div(Op)) begin
                        state_d = ST_DIV;
                        rem_d   = '0;
                        quo_d   = w_abs_a;
                        dvs_d   = w_abs_b;
                        if (w_early) begin
                            cnt_d   = '0;
                            early_d = 1'b1;
                        end else begin
                            cnt_d = CNT_W'(DIV_CYCLES - 1);
                        end
                    end else begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    state_d = ST_WRITE;
                    res_d   = w_prod;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                if (cnt_q == '0) begin
                    state_d = ST_WRITE;
                    res_d   = w_div_res;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                // A WB move owns the port this cycle; our result retries next cycle
                if (!w_move) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HiLoWe  = 2'b00;
        HiOut   = 32'd0;
        LoOut   = 32'd0;
        DivZero = 1'b0;
        if (w_move) begin
            HiLoWe = {MoveHiWe, MoveLoWe};
            HiOut  = MoveData;
            LoOut  = MoveData;
        end else if (state_q == ST_WRITE) begin
            HiLoWe  = 2'b11;
            HiOut   = w_wr_data[63:32];
            LoOut   = w_wr_data[31:0];
            DivZero = op_is_div(op_q) && (b_q == 32'd0);
        end
    end

    assign Busy  = (state_q != ST_IDLE);
    assign Stall = Busy & ((Start & op_legal(Op)) | HiLoRead);

endmodule

`default_nettype wire
